// File: rtl/pic_bus_master_if.sv
// Host-request, init-sequencer and 8259A bus signals of pic_bus_master.
// master: the initiator's view; slave: the host/PIC side (testbench).
interface pic_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic       req_a0;
    logic [7:0] req_data;
    logic       cmd_done;
    logic [7:0] rsp_data;
    logic       init_start;
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic       init_busy;
    logic       init_done;
    logic       chip_select_bar;
    logic       write_bar;
    logic       read_bar;
    logic       A0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    modport master (
        input  req_valid, req_write, req_a0, req_data,
        input  init_start, icw1, icw2, icw3, icw4, data_in,
        output req_ready, cmd_done, rsp_data, init_busy, init_done,
        output chip_select_bar, write_bar, read_bar, A0, data_out, data_oe
    );

    modport slave (
        output req_valid, req_write, req_a0, req_data,
        output init_start, icw1, icw2, icw3, icw4, data_in,
        input  req_ready, cmd_done, rsp_data, init_busy, init_done,
        input  chip_select_bar, write_bar, read_bar, A0, data_out, data_oe
    );
endinterface

// File: rtl/pic_bus_master.sv
// CPU-side 8259A bus initiator: timed CS#/WR#/RD#/A0/data cycles for host requests.
// Define PIC_MASTER_INIT_SEQ_EN to include the ICW1..ICW4 init sequencer.
module pic_bus_master #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 1
) (
    input logic              clk,
    input logic              reset,
    pic_bus_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_q, wr_d, a0_q, a0_d, init_q, init_d;
    logic [7:0]  dat_q, dat_d, rsp_q, rsp_d;
    logic        csb_q, csb_d, wrb_q, wrb_d, rdb_q, rdb_d, oe_q, oe_d;
    logic        done_q, done_d;
    logic        active_d;

`ifdef PIC_MASTER_INIT_SEQ_EN
    logic        busy_q, busy_d, idone_q, idone_d, more_q, more_d;
    logic [1:0]  word_q, word_d;
    logic [7:0]  icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0]  word_data;

    always_comb begin
        unique case (word_q)
            2'd1:    word_data = icw2_q;
            2'd2:    word_data = icw3_q;
            default: word_data = icw4_q;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE) & ~busy_q & ~bus.init_start & ~reset;
    assign bus.init_busy = busy_q;
    assign bus.init_done = idone_q;
`else
    assign bus.req_ready = (state_q == IDLE) & ~reset;
    assign bus.init_busy = 1'b0;
    assign bus.init_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        a0_d    = a0_q;
        dat_d   = dat_q;
        init_d  = init_q;
        rsp_d   = rsp_q;
        done_d  = 1'b0;
`ifdef PIC_MASTER_INIT_SEQ_EN
        busy_d  = busy_q;
        idone_d = 1'b0;
        more_d  = more_q;
        word_d  = word_q;
        icw1_d  = icw1_q;
        icw2_d  = icw2_q;
        icw3_d  = icw3_q;
        icw4_d  = icw4_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_valid && bus.req_ready) begin
                    state_d = SETUP;
                    wr_d    = bus.req_write;
                    a0_d    = bus.req_a0;
                    dat_d   = bus.req_data;
                    init_d  = 1'b0;
                end
`ifdef PIC_MASTER_INIT_SEQ_EN
                else if (bus.init_start && !busy_q) begin
                    // ICW1 goes out straight away; bit4 marks it as ICW1 to the PIC
                    icw1_d  = bus.icw1;
                    icw2_d  = bus.icw2;
                    icw3_d  = bus.icw3;
                    icw4_d  = bus.icw4;
                    busy_d  = 1'b1;
                    more_d  = 1'b0;
                    word_d  = 2'd0;
                    state_d = SETUP;
                    wr_d    = 1'b1;
                    a0_d    = 1'b0;
                    dat_d   = bus.icw1 | 8'h10;
                    init_d  = 1'b1;
                end else if (busy_q && more_q) begin
                    more_d  = 1'b0;
                    state_d = SETUP;
                    wr_d    = 1'b1;
                    a0_d    = 1'b1;
                    dat_d   = word_data;
                    init_d  = 1'b1;
                end
`endif
            end
            SETUP: begin
                if (cnt_q == 16'(SETUP_CYCLES - 1)) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 16'(STROBE_CYCLES - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (!wr_q) rsp_d = bus.data_in;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
                    state_d = (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
                    cnt_d   = '0;
                    if (!init_q) done_d = 1'b1;
`ifdef PIC_MASTER_INIT_SEQ_EN
                    // Pick the next ICW: ICW3 only when cascaded, ICW4 only when requested
                    else begin
                        more_d = 1'b1;
                        unique case (word_q)
                            2'd0: word_d = 2'd1;
                            2'd1: begin
                                if (!icw1_q[1])     word_d = 2'd2;
                                else if (icw1_q[0]) word_d = 2'd3;
                                else begin more_d = 1'b0; idone_d = 1'b1; end
                            end
                            2'd2: begin
                                if (icw1_q[0]) word_d = 2'd3;
                                else begin more_d = 1'b0; idone_d = 1'b1; end
                            end
                            default: begin more_d = 1'b0; idone_d = 1'b1; end
                        endcase
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 16'(RECOVERY_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PIC_MASTER_INIT_SEQ_EN
        if (idone_q) busy_d = 1'b0;
`endif
        active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        csb_d    = ~active_d;
        wrb_d    = ~((state_d == STROBE) && wr_d);
        rdb_d    = ~((state_d == STROBE) && !wr_d);
        oe_d     = active_d && wr_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            a0_q    <= 1'b0;
            dat_q   <= '0;
            init_q  <= 1'b0;
            rsp_q   <= '0;
            done_q  <= 1'b0;
            csb_q   <= 1'b1;
            wrb_q   <= 1'b1;
            rdb_q   <= 1'b1;
            oe_q    <= 1'b0;
`ifdef PIC_MASTER_INIT_SEQ_EN
            busy_q  <= 1'b0;
            idone_q <= 1'b0;
            more_q  <= 1'b0;
            word_q  <= '0;
            icw1_q  <= '0;
            icw2_q  <= '0;
            icw3_q  <= '0;
            icw4_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            a0_q    <= a0_d;
            dat_q   <= dat_d;
            init_q  <= init_d;
            rsp_q   <= rsp_d;
            done_q  <= done_d;
            csb_q   <= csb_d;
            wrb_q   <= wrb_d;
            rdb_q   <= rdb_d;
            oe_q    <= oe_d;
`ifdef PIC_MASTER_INIT_SEQ_EN
            busy_q  <= busy_d;
            idone_q <= idone_d;
            more_q  <= more_d;
            word_q  <= word_d;
            icw1_q  <= icw1_d;
            icw2_q  <= icw2_d;
            icw3_q  <= icw3_d;
            icw4_q  <= icw4_d;
`endif
        end
    end

    assign bus.chip_select_bar = csb_q;
    assign bus.write_bar       = wrb_q;
    assign bus.read_bar        = rdb_q;
    assign bus.A0              = a0_q;
    assign bus.data_out        = dat_q;
    assign bus.data_oe         = oe_q;
    assign bus.cmd_done        = done_q;
    assign bus.rsp_data        = rsp_q;
endmodule

// File: tb/tb_pic_bus_master.sv
// Directed bench for pic_bus_master with default timing parameters; init tests
// run only when PIC_MASTER_INIT_SEQ_EN is defined, otherwise init_start must be ignored.
module tb_pic_bus_master;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pic_bus_master_if bus();

    pic_bus_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checkCount = 0;
    int         errorCount = 0;
    int         cmdDoneCount = 0;
    int         initDoneCount = 0;
    logic       prevWrb = 1'b1;
    logic [8:0] wordLog[$];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Logs every write word as {A0,data} on the falling edge of WR#
    always @(negedge clk) begin
        if (reset) begin
            prevWrb = 1'b1;
        end else begin
            if (!bus.write_bar && prevWrb) wordLog.push_back({bus.A0, bus.data_out});
            prevWrb = bus.write_bar;
            if (bus.cmd_done) cmdDoneCount++;
            if (bus.init_done) initDoneCount++;
        end
    end

    // One host access from an IDLE negedge (T0) through T6
    task automatic applyStimulus(input logic wr, input logic a0, input logic [7:0] d,
                                 input logic [7:0] din);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_a0    = a0;
        bus.req_data  = d;
        bus.data_in   = din;
        checkOutput("req_ready T0", int'(bus.req_ready), 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            checkOutput($sformatf("cs_n T%0d", k), int'(bus.chip_select_bar),
                        (k >= 1 && k <= 4) ? 0 : 1);
            checkOutput($sformatf("wr_n T%0d", k), int'(bus.write_bar),
                        (wr && (k == 2 || k == 3)) ? 0 : 1);
            checkOutput($sformatf("rd_n T%0d", k), int'(bus.read_bar),
                        (!wr && (k == 2 || k == 3)) ? 0 : 1);
            checkOutput($sformatf("data_oe T%0d", k), int'(bus.data_oe),
                        (wr && k >= 1 && k <= 4) ? 1 : 0);
            checkOutput($sformatf("cmd_done T%0d", k), int'(bus.cmd_done), (k == 5) ? 1 : 0);
            if (k <= 4) checkOutput($sformatf("A0 T%0d", k), int'(bus.A0), int'(a0));
            if (wr && k <= 4) checkOutput($sformatf("data_out T%0d", k), int'(bus.data_out), int'(d));
            if (!wr && k == 5) checkOutput("rsp_data", int'(bus.rsp_data), int'(din));
            if (k == 6) checkOutput("req_ready T6", int'(bus.req_ready), 1);
        end
    endtask

`ifdef PIC_MASTER_INIT_SEQ_EN
    task automatic runInit(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3,
                           input logic [7:0] i4, input int nWords, input logic [8:0] w0,
                           input logic [8:0] w1, input logic [8:0] w2, input logic [8:0] w3);
        logic [8:0] exp[4];
        int budget;
        int cmdBefore;
        int doneBefore;
        exp = '{w0, w1, w2, w3};
        wordLog.delete();
        cmdBefore  = cmdDoneCount;
        doneBefore = initDoneCount;
        bus.icw1 = i1; bus.icw2 = i2; bus.icw3 = i3; bus.icw4 = i4;
        bus.init_start = 1'b1;
        checkOutput("req_ready during init_start", int'(bus.req_ready), 0);
        @(negedge clk);
        bus.init_start = 1'b0;
        checkOutput("init_busy rise", int'(bus.init_busy), 1);
        budget = 0;
        while (!bus.init_done && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("init_done timeout", int'(budget < 200), 1);
        checkOutput("init_busy with done", int'(bus.init_busy), 1);
        @(negedge clk);
        checkOutput("init_busy fall", int'(bus.init_busy), 0);
        checkOutput("init_done width", int'(bus.init_done), 0);
        checkOutput("init_done count", initDoneCount - doneBefore, 1);
        checkOutput("icw word count", wordLog.size(), nWords);
        for (int i = 0; i < nWords && i < wordLog.size(); i++)
            checkOutput($sformatf("icw word %0d", i), int'(wordLog[i]), int'(exp[i]));
        checkOutput("no cmd_done in init", cmdDoneCount - cmdBefore, 0);
    endtask
`endif

    initial begin
        int budget;
        int cmdBefore;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_a0 = 1'b0; bus.req_data = '0;
        bus.init_start = 1'b0; bus.icw1 = '0; bus.icw2 = '0; bus.icw3 = '0; bus.icw4 = '0;
        bus.data_in = '0;
        #12;
        checkOutput("reset cs_n", int'(bus.chip_select_bar), 1);
        checkOutput("reset wr_n", int'(bus.write_bar), 1);
        checkOutput("reset rd_n", int'(bus.read_bar), 1);
        checkOutput("reset A0", int'(bus.A0), 0);
        checkOutput("reset data_out", int'(bus.data_out), 0);
        checkOutput("reset data_oe", int'(bus.data_oe), 0);
        checkOutput("reset rsp_data", int'(bus.rsp_data), 0);
        checkOutput("reset init_busy", int'(bus.init_busy), 0);
        checkOutput("reset req_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] host write and read");
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h3C);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'hC7);

`ifdef PIC_MASTER_INIT_SEQ_EN
        $display("[TB] init sequences");
        runInit(8'h11, 8'h20, 8'h04, 8'h01, 4, 9'h011, 9'h120, 9'h104, 9'h101);
        runInit(8'h02, 8'h55, 8'hEE, 8'hFF, 2, 9'h012, 9'h155, 9'h000, 9'h000);
        runInit(8'h03, 8'h40, 8'hEE, 8'h1D, 3, 9'h013, 9'h140, 9'h11D, 9'h000);

        $display("[TB] init_start and request together");
        wordLog.delete();
        bus.icw1 = 8'h02; bus.icw2 = 8'h33;
        bus.init_start = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_a0 = 1'b1; bus.req_data = 8'hC3;
        checkOutput("req_ready vs init_start", int'(bus.req_ready), 0);
        @(negedge clk);
        bus.init_start = 1'b0;
        budget = 0;
        while (!bus.req_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("req_ready timeout", int'(budget < 300), 1);
        checkOutput("busy at first ready", int'(bus.init_busy), 0);
        checkOutput("words before request", wordLog.size(), 2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        budget = 0;
        while (!bus.cmd_done && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("cmd_done timeout", int'(budget < 50), 1);
        checkOutput("words after request", wordLog.size(), 3);
        if (wordLog.size() == 3) checkOutput("host word after init", int'(wordLog[2]), 9'h1C3);
        repeat (2) @(negedge clk);
`else
        $display("[TB] init_start ignored");
        wordLog.delete();
        bus.icw1 = 8'h11;
        bus.init_start = 1'b1;
        checkOutput("req_ready ignores init_start", int'(bus.req_ready), 1);
        @(negedge clk);
        bus.init_start = 1'b0;
        checkOutput("init_busy tied", int'(bus.init_busy), 0);
        repeat (4) @(negedge clk);
        checkOutput("no init cycle cs_n", int'(bus.chip_select_bar), 1);
        checkOutput("no init words", wordLog.size(), 0);
        checkOutput("no init_done", initDoneCount, 0);
`endif

        $display("[TB] reset during strobe");
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_a0 = 1'b1; bus.req_data = 8'h77;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre-abort wr_n", int'(bus.write_bar), 0);
        cmdBefore = cmdDoneCount;
        #1 reset = 1'b1;
        #1;
        checkOutput("abort wr_n", int'(bus.write_bar), 1);
        checkOutput("abort cs_n", int'(bus.chip_select_bar), 1);
        checkOutput("abort data_oe", int'(bus.data_oe), 0);
        checkOutput("abort req_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort no cmd_done", cmdDoneCount - cmdBefore, 0);
        checkOutput("abort idle cs_n", int'(bus.chip_select_bar), 1);
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
